// File: rtl/exp_pkg.sv
// Shared constants for the piecewise-linear e^x array.
// Holds log2(e), the default 2^f segment table and its index type.
package exp_pkg;

    localparam int LOG2E = 6051102;
    localparam int TAB_SEG_BITS = 3;

    typedef logic [TAB_SEG_BITS-1:0] coef_idx_t;

    // Default slope of each 2^f segment, Q22
    function automatic logic [31:0] k_def(input coef_idx_t i);
        logic [31:0] r;
        r = '0;
        unique case (i)
            3'd0: r = 32'h002E5707;
            3'd1: r = 32'h003288B9;
            3'd2: r = 32'h00371B99;
            3'd3: r = 32'h003C1872;
            3'd4: r = 32'h004188DB;
            3'd5: r = 32'h0047774A;
            3'd6: r = 32'h004DEF28;
            3'd7: r = 32'h0054FCE4;
        endcase
        return r;
    endfunction

    // Default intercept of each 2^f segment, Q22
    function automatic logic [31:0] b_def(input coef_idx_t i);
        logic [31:0] r;
        r = '0;
        unique case (i)
            3'd0: r = 32'h00400000;
            3'd1: r = 32'h003F79C9;
            3'd2: r = 32'h003E5511;
            3'd3: r = 32'h003C7640;
            3'd4: r = 32'h0039BE0B;
            3'd5: r = 32'h00360906;
            3'd6: r = 32'h00312F20;
            3'd7: r = 32'h002B031B;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pwl_exp_lane.sv
// One lane of the e^x datapath: S1 scale by log2(e), S2 split,
// S3 segment multiply-add, S4 shift by the integer part.
module pwl_exp_lane
    import exp_pkg::*;
#(
    parameter int Q        = 22,
    parameter int W        = 32,
    parameter int SEG_BITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic [SEG_BITS-1:0] seg,
    input  logic signed [W-1:0] k,
    input  logic signed [W-1:0] b,
    output logic [W-1:0]        y,
    output logic                sat
);

    localparam int PW  = 2 * W;
    localparam int SHW = $clog2(W);
    localparam logic signed [W-1:0] L2E = W'(LOG2E);

    logic                 xpos;
    logic signed [W-1:0]  xc;
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] s1_y;
    logic                 s1_sat;

    logic signed [PW-1:0] ip;
    logic signed [PW-1:0] ni;
    logic [Q-1:0]         s2_f;
    logic signed [W-1:0]  s2_k;
    logic signed [W-1:0]  s2_b;
    logic [SHW-1:0]       s2_sh;
    logic                 s2_z;
    logic                 s2_sat;

    logic signed [PW-1:0] ke;
    logic signed [PW-1:0] fe;
    logic signed [PW-1:0] m;
    logic signed [PW-1:0] s3_m;
    logic [SHW-1:0]       s3_sh;
    logic                 s3_z;
    logic                 s3_sat;

    // Positive exponents saturate to e^0
    always_comb begin
        xpos = !x[W-1] && (x != '0);
        xc   = xpos ? '0 : x;
    end

    assign p1  = PW'(xc) * PW'(L2E);
    assign ip  = s1_y >>> Q;
    assign ni  = -ip;
    assign seg = s1_y[Q-1 -: SEG_BITS];
    assign ke  = PW'(s2_k);
    assign fe  = PW'($signed({1'b0, s2_f}));
    assign m   = ((ke * fe) >>> Q) + PW'(s2_b);

    // S1: y = x * log2(e), truncated back to Q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_y   <= '0;
            s1_sat <= 1'b0;
        end else if (en) begin
            s1_y   <= p1 >>> Q;
            s1_sat <= xpos;
        end
    end

    // S2: split into integer/fraction and latch the segment coefficients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_f   <= '0;
            s2_k   <= '0;
            s2_b   <= '0;
            s2_sh  <= '0;
            s2_z   <= 1'b0;
            s2_sat <= 1'b0;
        end else if (en) begin
            s2_f   <= s1_y[Q-1:0];
            s2_k   <= k;
            s2_b   <= b;
            s2_sh  <= ni[SHW-1:0];
            s2_z   <= ni >= PW'(W);
            s2_sat <= s1_sat;
        end
    end

    // S3: mantissa m = k*f + b for the selected segment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_m   <= '0;
            s3_sh  <= '0;
            s3_z   <= 1'b0;
            s3_sat <= 1'b0;
        end else if (en) begin
            s3_m   <= m;
            s3_sh  <= s2_sh;
            s3_z   <= s2_z;
            s3_sat <= s2_sat;
        end
    end

    // S4: scale by 2^I, flushing to zero when fully shifted out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (en) begin
            y   <= s3_z ? '0 : W'(s3_m >>> s3_sh);
            sat <= s3_sat;
        end
    end

endmodule

// File: rtl/pwl_exp_array.sv
// Multi-lane e^x unit with one valid/ready handshake and a
// writable piecewise-linear coefficient table shared by all lanes.
module pwl_exp_array
    import exp_pkg::*;
#(
    parameter int Q        = 22,
    parameter int W        = 32,
    parameter int SEG_BITS = 3,
    parameter int LANES    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0][W-1:0]   in_x,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0][W-1:0]   out_y,
    output logic [LANES-1:0]          out_sat,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [SEG_BITS-1:0]       cfg_addr,
    input  logic [W-1:0]              cfg_wdata
);

    localparam int NSEG = 1 << SEG_BITS;

    logic v1, v2, v3, v4;
    logic en;
    logic signed [W-1:0] k_tab [NSEG];
    logic signed [W-1:0] b_tab [NSEG];
    logic [SEG_BITS-1:0] seg [LANES];

    assign en        = !v4 || out_ready;
    assign in_ready  = en;
    assign out_valid = v4;

    // Stage valid chain; bubbles advance with the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
        end
    end

    // Coefficient table: defaults on reset, writes ignore the stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                k_tab[i] <= W'(k_def(coef_idx_t'(i)));
                b_tab[i] <= W'(b_def(coef_idx_t'(i)));
            end
        end else if (cfg_we) begin
            if (cfg_sel)
                b_tab[cfg_addr] <= cfg_wdata;
            else
                k_tab[cfg_addr] <= cfg_wdata;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pwl_exp_lane #(
            .Q        (Q),
            .W        (W),
            .SEG_BITS (SEG_BITS)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .x     (in_x[g]),
            .seg   (seg[g]),
            .k     (k_tab[seg[g]]),
            .b     (b_tab[seg[g]]),
            .y     (out_y[g]),
            .sat   (out_sat[g])
        );
    end

endmodule

// File: tb/tb_pwl_exp_array.sv
// Bench for pwl_exp_array: vector table through a scoreboard,
// plus stall, coefficient-write and mid-flight reset sequences.
module tb_pwl_exp_array;

    localparam int LN = 4;

    typedef logic [LN-1:0][31:0] lanes_t;

    typedef struct {
        lanes_t            x;
        lanes_t            y;
        logic [LN-1:0][7:0] tol;
        logic [LN-1:0]     sat;
        bit                mdl;
    } vec_t;

    typedef struct {
        lanes_t            y;
        logic [LN-1:0][7:0] tol;
        logic [LN-1:0]     sat;
        int                stamp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    lanes_t       in_x;
    logic         out_valid;
    logic         out_ready;
    lanes_t       out_y;
    logic [LN-1:0] out_sat;
    logic         cfg_we;
    logic         cfg_sel;
    logic [2:0]   cfg_addr;
    logic [31:0]  cfg_wdata;

    int  applied = 0;
    int  errs = 0;
    int  cyc = 0;
    bit  chk_lat = 1'b0;
    int  stall_seen = 0;
    exp_t sb[$];
    longint kk[8];
    longint bb[8];
    vec_t vt[$];

    bit     stl = 1'b0;
    lanes_t hy;
    logic [LN-1:0] hs;

    pwl_exp_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sat   (out_sat),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic load_def();
        kk = '{64'h002E5707, 64'h003288B9, 64'h00371B99, 64'h003C1872,
               64'h004188DB, 64'h0047774A, 64'h004DEF28, 64'h0054FCE4};
        bb = '{64'h00400000, 64'h003F79C9, 64'h003E5511, 64'h003C7640,
               64'h0039BE0B, 64'h00360906, 64'h00312F20, 64'h002B031B};
    endtask

    // Reference e^x from the fixed-point recipe, using the bench's table
    function automatic logic [31:0] model(input logic [31:0] x);
        longint xs, yv, ip, f, m, n;
        int s;
        xs = longint'($signed(x));
        if (xs > 0) xs = 0;
        yv = (xs * 64'sd6051102) >>> 22;
        ip = yv >>> 22;
        f  = yv & 64'h3FFFFF;
        s  = int'(f >> 19);
        m  = ((kk[s] * f) >>> 22) + bb[s];
        n  = -ip;
        if (n >= 32) return 32'h0;
        return 32'(m >>> n);
    endfunction

    function automatic lanes_t l4(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        lanes_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic vec_t mv(input lanes_t x);
        vec_t v;
        v.x = x; v.y = '0; v.tol = '0; v.sat = '0; v.mdl = 1'b1;
        return v;
    endfunction

    function automatic vec_t cv(input lanes_t x, input lanes_t y,
                                input logic [LN-1:0][7:0] t,
                                input logic [LN-1:0] s);
        vec_t v;
        v.x = x; v.y = y; v.tol = t; v.sat = s; v.mdl = 1'b0;
        return v;
    endfunction

    function automatic exp_t mk(input vec_t v);
        exp_t e;
        for (int l = 0; l < LN; l++) begin
            if (v.mdl) begin
                e.y[l]   = model(v.x[l]);
                e.tol[l] = 8'd0;
                e.sat[l] = $signed(v.x[l]) > 0;
            end else begin
                e.y[l]   = v.y[l];
                e.tol[l] = v.tol[l];
                e.sat[l] = v.sat[l];
            end
        end
        e.stamp = 0;
        return e;
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at next posedge+1
    task automatic step(input bit v, input vec_t vec, output bit acc);
        exp_t e;
        in_valid = v;
        in_x = vec.x;
        #2;
        acc = v && in_ready;
        if (acc) begin
            e = mk(vec);
            e.stamp = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        vec_t z;
        z = mv('0);
        for (int i = 0; i < n; i++) step(1'b0, z, acc);
    endtask

    task automatic send(input vec_t v);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, v, acc);
        if (!acc) begin
            applied++; errs++;
            $display("FAIL accept_timeout in_ready stayed 0, want 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            applied++; errs++;
            $display("FAIL drain_timeout %0d results missing, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Output monitor: reset state, stall hold, scoreboard and latency
    always @(negedge clk) begin
        exp_t e;
        int d;
        if (!rst_n) begin
            stl = 1'b0;
            applied++;
            if (out_valid !== 1'b0 || out_y !== '0 || out_sat !== '0 ||
                in_ready !== 1'b1) begin
                errs++;
                $display("FAIL reset_state ov=%b y=%h sat=%b rdy=%b, want 0/0/0/1",
                         out_valid, out_y, out_sat, in_ready);
            end
        end else begin
            if (stl) begin
                applied++;
                if (out_valid !== 1'b1 || out_y !== hy || out_sat !== hs) begin
                    errs++;
                    $display("FAIL stall_hold ov=%b y=%h sat=%b, want 1 y=%h sat=%b",
                             out_valid, out_y, out_sat, hy, hs);
                end
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                applied++;
                if (in_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL in_ready_stall got %b want 0", in_ready);
                end
                stl = 1'b1;
                hy = out_y;
                hs = out_sat;
            end else begin
                stl = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    applied++; errs++;
                    $display("FAIL unexpected_out y=%h, want no out_valid", out_y);
                end else begin
                    e = sb.pop_front();
                    for (int l = 0; l < LN; l++) begin
                        applied++;
                        d = int'($signed(out_y[l])) - int'($signed(e.y[l]));
                        if (d < 0) d = -d;
                        if (d > int'(e.tol[l]) || out_sat[l] !== e.sat[l]) begin
                            errs++;
                            $display("FAIL lane%0d y got %h want %h tol %0d sat got %b want %b",
                                     l, out_y[l], e.y[l], e.tol[l], out_sat[l], e.sat[l]);
                        end
                    end
                    if (chk_lat) begin
                        applied++;
                        if (cyc - e.stamp != 4) begin
                            errs++;
                            $display("FAIL latency got %0d want 4", cyc - e.stamp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        errs++;
        $display("FAIL watchdog simulation time limit reached, want finish");
        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int i;
        vec_t sv[6];

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_sel = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        load_def();

        vt.push_back(cv(l4(0, 0, 0, 0),
                        l4(32'h400000, 32'h400000, 32'h400000, 32'h400000),
                        '0, 4'b0000));
        vt.push_back(cv(l4(32'hFFD3A37A, 32'hF8000000, 32'h00400000, 32'h7FFFFFFF),
                        l4(32'h200000, 32'h0, 32'h400000, 32'h400000),
                        {8'd0, 8'd0, 8'd0, 8'd2}, 4'b1100));
        vt.push_back(mv(l4(32'hFFE00000, 32'hFFA00000, 32'hFF300000, 32'hFD800000)));
        vt.push_back(mv(l4(32'h80000000, 32'hFFFFFFFF, 32'hFFC00000, 32'hF8A432EB)));
        vt.push_back(mv(l4(32'h00000001, 32'hFFD00000, 32'hFFE55556, 32'hFFF10000)));
        vt.push_back(mv(l4(32'hFE000000, 32'hFF800000, 32'hFFF80000, 32'hFFFFF000)));

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        chk_lat = 1'b1;
        foreach (vt[n]) send(vt[n]);
        drain();

        chk_lat = 1'b0;
        for (int n = 0; n < 6; n++)
            sv[n] = mv(l4(32'hFFF00000 - 32'(n * 32'h00123457),
                          32'hFFC00000 - 32'(n * 32'h00080000),
                          32'(n),
                          32'hFF000000 + 32'(n * 32'h00100000)));
        stall_seen = 0;
        i = 0;
        for (int t = 0; t < 40 && i < 6; t++) begin
            out_ready = !(t >= 5 && t <= 7);
            step(1'b1, sv[i], acc);
            if (acc) i++;
        end
        in_valid = 1'b0;
        applied++;
        if (i != 6 || stall_seen < 3) begin
            errs++;
            $display("FAIL stall_stream sent %0d stalls %0d, want 6 and >=3", i, stall_seen);
        end
        drain();

        chk_lat = 1'b1;
        cfg_we = 1'b1;
        cfg_sel = 1'b0;
        cfg_addr = 3'd0;
        cfg_wdata = 32'h0;
        idle(1);
        cfg_sel = 1'b1;
        cfg_wdata = 32'h00200000;
        idle(1);
        cfg_we = 1'b0;
        kk[0] = 0;
        bb[0] = 64'h00200000;
        send(cv(l4(0, 0, 0, 0),
                l4(32'h200000, 32'h200000, 32'h200000, 32'h200000),
                '0, 4'b0000));
        send(mv(l4(32'hFFF00000, 32'hFFC80000, 32'h00000000, 32'hFFFF0000)));
        drain();

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        load_def();
        idle(1);
        send(cv(l4(0, 0, 0, 0),
                l4(32'h400000, 32'h400000, 32'h400000, 32'h400000),
                '0, 4'b0000));
        drain();

        send(mv(l4(32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000)));
        send(mv(l4(32'hFFA00000, 32'hFFA00000, 32'hFFA00000, 32'hFFA00000)));
        send(mv(l4(32'hFF300000, 32'hFF300000, 32'hFF300000, 32'hFF300000)));
        rst_n = 1'b0;
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            applied++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL flushed_out ov got %b want 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send(mv(l4(32'hFFE00000, 32'h0, 32'hFF000000, 32'h00400000)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
